// File: rtl/keccak_padder_p_if.sv
// Word-in / block-out bus between a message source, the padder and the permutation.
// The source side uses master; the padder uses slave.
interface keccak_padder_p_if #(
  parameter int unsigned IN_W = 32,
  parameter int unsigned RATE = 576
);
  localparam int unsigned BN_W = $clog2(IN_W / 8);

  logic [IN_W-1:0] in;
  logic            in_ready;
  logic            is_last;
  logic [BN_W-1:0] byte_num;
  logic            f_ack;
  logic            buffer_full;
  logic [RATE-1:0] out;
  logic            out_ready;
  logic            last_block;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, last_block
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, last_block
  );
endinterface

// File: rtl/keccak_padder_p.sv
// Keccak/SHA-3 message padder: packs IN_W-bit words into RATE-bit blocks and applies
// PAD_BYTE ... 0x80 multi-rate padding to the final, partial word.
module keccak_padder_p #(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned RATE     = 576,
  parameter logic [7:0]  PAD_BYTE = 8'h01
) (
  input logic              clk,
  input logic              reset,
  keccak_padder_p_if.slave bus
);
  localparam int unsigned NW    = RATE / IN_W;
  localparam int unsigned NB    = IN_W / 8;
  localparam int unsigned CNT_W = $clog2(NW);

  typedef enum logic [1:0] {StAccept, StFull, StDone} state_e;

  state_e           state_q, state_d;
  logic [RATE-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             full_q, full_d;

  logic             accept;
  logic [IN_W-1:0]  pad_word;
  logic [IN_W-1:0]  slot_word;
  logic [RATE-1:0]  placed;

  // Final word: keep byte_num leading bytes, then PAD_BYTE, then zeros.
  always_comb begin
    pad_word = '0;
    for (int b = 0; b < int'(NB); b++) begin
      if (b < int'(bus.byte_num)) begin
        pad_word[IN_W-1-8*b -: 8] = bus.in[IN_W-1-8*b -: 8];
      end else if (b == int'(bus.byte_num)) begin
        pad_word[IN_W-1-8*b -: 8] = PAD_BYTE;
      end
    end
  end

  assign accept    = bus.in_ready && !full_q && (state_q == StAccept);
  assign slot_word = bus.is_last ? pad_word : bus.in;
  // Unwritten slots are always zero, so OR-ing the shifted word in fills slot cnt.
  assign placed    = {slot_word, {(RATE-IN_W){1'b0}}} >> (cnt_q * IN_W);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    full_d  = full_q;
    unique case (state_q)
      StAccept: begin
        if (accept) begin
          if (bus.is_last) begin
            buf_d   = buf_q | placed | {{(RATE-8){1'b0}}, 8'h80};
            state_d = StFull;
            last_d  = 1'b1;
            full_d  = 1'b1;
          end else begin
            buf_d = buf_q | placed;
            if (cnt_q == CNT_W'(NW - 1)) begin
              state_d = StFull;
              last_d  = 1'b0;
              full_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      StFull: begin
        if (bus.f_ack) begin
          buf_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = last_q ? StDone : StAccept;
          full_d  = last_q;
        end
      end
      StDone: begin
        full_d = 1'b1;
      end
      default: begin
        state_d = StAccept;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StAccept;
      buf_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      full_q  <= full_d;
    end
  end

  assign bus.buffer_full = full_q;
  assign bus.out         = buf_q;
  assign bus.out_ready   = (state_q == StFull);
  assign bus.last_block  = last_q;
endmodule

// File: tb/tb_keccak_padder_p.sv
// Directed bench for keccak_padder_p: default configuration plus a 64-bit/1088/SHA-3 instance.
module tb_keccak_padder_p;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  keccak_padder_p_if #(.IN_W(32), .RATE(576))  bus_a ();
  keccak_padder_p_if #(.IN_W(64), .RATE(1088)) bus_b ();

  keccak_padder_p #(.IN_W(32), .RATE(576), .PAD_BYTE(8'h01)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  keccak_padder_p #(.IN_W(64), .RATE(1088), .PAD_BYTE(8'h06)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1151:0] obs, input logic [1151:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wa(input logic [31:0] w, input logic last, input logic [1:0] bn);
    bus_a.in       = w;
    bus_a.in_ready = 1'b1;
    bus_a.is_last  = last;
    bus_a.byte_num = bn;
    tick();
    bus_a.in_ready = 1'b0;
    bus_a.is_last  = 1'b0;
  endtask

  task automatic wb(input logic [63:0] w, input logic last, input logic [2:0] bn);
    bus_b.in       = w;
    bus_b.in_ready = 1'b1;
    bus_b.is_last  = last;
    bus_b.byte_num = bn;
    tick();
    bus_b.in_ready = 1'b0;
    bus_b.is_last  = 1'b0;
  endtask

  task automatic ack_a();
    bus_a.f_ack = 1'b1;
    tick();
    bus_a.f_ack = 1'b0;
  endtask

  task automatic msg_a();
    wa(32'h48656c6c, 1'b0, 2'd0);  // "Hell"
    wa(32'h6f2c2077, 1'b0, 2'd0);  // "o, w"
    wa(32'h6f726c64, 1'b0, 2'd0);  // "orld"
    wa(32'h21202020, 1'b1, 2'd1);  // "!" + 3 ignored bytes
  endtask

  function automatic logic [575:0] put_a(input logic [575:0] v, input int slot,
                                         input logic [31:0] w);
    v[575-32*slot -: 32] = w;
    return v;
  endfunction

  function automatic logic [1087:0] put_b(input logic [1087:0] v, input int slot,
                                          input logic [63:0] w);
    v[1087-64*slot -: 64] = w;
    return v;
  endfunction

  logic [575:0]  exp_a;
  logic [575:0]  exp_msg;
  logic [1087:0] exp_b;

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    n_cmp = 0;
    n_bad = 0;
    bus_a.in = '0; bus_a.in_ready = 1'b0; bus_a.is_last = 1'b0;
    bus_a.byte_num = '0; bus_a.f_ack = 1'b0;
    bus_b.in = '0; bus_b.in_ready = 1'b0; bus_b.is_last = 1'b0;
    bus_b.byte_num = '0; bus_b.f_ack = 1'b0;
    do_reset();

    chkb("rst_out_ready", bus_a.out_ready, 1'b0);
    chkb("rst_buffer_full", bus_a.buffer_full, 1'b0);
    chkb("rst_last_block", bus_a.last_block, 1'b0);
    chk("rst_out", 1152'(bus_a.out), 1152'(0));

    // Empty message: one is_last word with byte_num=0.
    exp_a = '0;
    exp_a[575:568] = 8'h01;
    exp_a[7:0] = 8'h80;
    wa(32'hdeadbeef, 1'b1, 2'd0);
    chkb("empty_out_ready", bus_a.out_ready, 1'b1);
    chkb("empty_buffer_full", bus_a.buffer_full, 1'b1);
    chkb("empty_last_block", bus_a.last_block, 1'b1);
    chk("empty_out", 1152'(bus_a.out), 1152'(exp_a));
    ack_a();
    chkb("done_out_ready", bus_a.out_ready, 1'b0);
    chkb("done_buffer_full", bus_a.buffer_full, 1'b1);
    chk("done_out", 1152'(bus_a.out), 1152'(0));
    wa(32'h12345678, 1'b1, 2'd2);
    ack_a();
    chkb("done_ignore_ready", bus_a.out_ready, 1'b0);
    chk("done_ignore_out", 1152'(bus_a.out), 1152'(0));

    // "Hello, world!"
    exp_msg = '0;
    exp_msg = put_a(exp_msg, 0, 32'h48656c6c);
    exp_msg = put_a(exp_msg, 1, 32'h6f2c2077);
    exp_msg = put_a(exp_msg, 2, 32'h6f726c64);
    exp_msg = put_a(exp_msg, 3, 32'h21010000);
    exp_msg[7:0] = 8'h80;
    do_reset();
    wa(32'h48656c6c, 1'b0, 2'd0);
    wa(32'h6f2c2077, 1'b0, 2'd0);
    wa(32'h6f726c64, 1'b0, 2'd0);
    chkb("hello_not_ready", bus_a.out_ready, 1'b0);
    wa(32'h21202020, 1'b1, 2'd1);
    chkb("hello_out_ready", bus_a.out_ready, 1'b1);
    chkb("hello_last_block", bus_a.last_block, 1'b1);
    chk("hello_slot3", 1152'(bus_a.out[479:448]), 1152'(32'h21010000));
    chk("hello_tail", 1152'(bus_a.out[7:0]), 1152'(8'h80));
    chk("hello_out", 1152'(bus_a.out), 1152'(exp_msg));

    // Reset mid-message (with a word driven during reset) and in FULL.
    do_reset();
    wa(32'h48656c6c, 1'b0, 2'd0);
    wa(32'h6f2c2077, 1'b0, 2'd0);
    bus_a.in = 32'hffffffff;
    bus_a.in_ready = 1'b1;
    do_reset();
    bus_a.in_ready = 1'b0;
    chk("midrst_out", 1152'(bus_a.out), 1152'(0));
    msg_a();
    chkb("full_before_rst", bus_a.out_ready, 1'b1);
    do_reset();
    chkb("fullrst_out_ready", bus_a.out_ready, 1'b0);
    chkb("fullrst_buffer_full", bus_a.buffer_full, 1'b0);
    chkb("fullrst_last_block", bus_a.last_block, 1'b0);
    chk("fullrst_out", 1152'(bus_a.out), 1152'(0));
    msg_a();
    chk("rerun_out", 1152'(bus_a.out), 1152'(exp_msg));
    ack_a();
    chkb("rerun_done_ready", bus_a.out_ready, 1'b0);
    chkb("rerun_done_full", bus_a.buffer_full, 1'b1);

    // Two-block message: 18 full words, then a held word and simultaneous f_ack.
    do_reset();
    exp_a = '0;
    for (int i = 0; i < 18; i++) begin
      exp_a = put_a(exp_a, i, 32'(i + 1));
      wa(32'(i + 1), 1'b0, 2'd0);
    end
    chkb("blk1_out_ready", bus_a.out_ready, 1'b1);
    chkb("blk1_buffer_full", bus_a.buffer_full, 1'b1);
    chkb("blk1_last_block", bus_a.last_block, 1'b0);
    chk("blk1_out", 1152'(bus_a.out), 1152'(exp_a));
    bus_a.in = 32'haaaa0001;
    bus_a.in_ready = 1'b1;
    tick();
    chk("blk1_held_out", 1152'(bus_a.out), 1152'(exp_a));
    bus_a.in = 32'hcafe0000;
    bus_a.f_ack = 1'b1;
    tick();
    bus_a.f_ack = 1'b0;
    chkb("ack_out_ready", bus_a.out_ready, 1'b0);
    chkb("ack_buffer_full", bus_a.buffer_full, 1'b0);
    chk("ack_out", 1152'(bus_a.out), 1152'(0));
    tick();
    bus_a.in_ready = 1'b0;
    exp_a = '0;
    exp_a = put_a(exp_a, 0, 32'hcafe0000);
    chk("blk2_slot0", 1152'(bus_a.out), 1152'(exp_a));
    ack_a();
    chkb("accept_ack_ready", bus_a.out_ready, 1'b0);
    chk("accept_ack_out", 1152'(bus_a.out), 1152'(exp_a));
    for (int i = 1; i < 17; i++) begin
      exp_a = put_a(exp_a, i, 32'(32'h100 + i));
      wa(32'(32'h100 + i), 1'b0, 2'd0);
    end
    chkb("blk2_not_ready", bus_a.out_ready, 1'b0);
    wa(32'h11223344, 1'b1, 2'd3);
    exp_a = put_a(exp_a, 17, 32'h11223381);
    chkb("blk2_out_ready", bus_a.out_ready, 1'b1);
    chkb("blk2_last_block", bus_a.last_block, 1'b1);
    chk("blk2_out", 1152'(bus_a.out), 1152'(exp_a));

    // SHA-3 padding, 64-bit words, pad byte lands on the final byte.
    exp_b = '0;
    for (int i = 0; i < 16; i++) begin
      exp_b = put_b(exp_b, i, {32'hf00d0000, 32'(i)});
      wb({32'hf00d0000, 32'(i)}, 1'b0, 3'd0);
    end
    chkb("b_not_ready", bus_b.out_ready, 1'b0);
    wb(64'h0102030405060708, 1'b1, 3'd7);
    exp_b = put_b(exp_b, 16, 64'h0102030405060786);
    chkb("b_out_ready", bus_b.out_ready, 1'b1);
    chkb("b_last_block", bus_b.last_block, 1'b1);
    chk("b_tail", 1152'(bus_b.out[7:0]), 1152'(8'h86));
    chk("b_out", 1152'(bus_b.out), 1152'(exp_b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/keccak_padder_p.md
KECCAK_PADDER_P -- requirements
Module: keccak_padder_p

Interface
REQ-001 Parameter IN_W, default 32, meaning input word width in bits; legal values are 32 and 64.
REQ-002 Parameter RATE, default 576, meaning block width in bits; legal values are 576, 832, 1088 and 1152, and RATE SHALL be a multiple of IN_W.
REQ-003 Parameter PAD_BYTE, default 8'h01, meaning first padding byte; 8'h01 selects Keccak padding and 8'h06 selects SHA-3 padding.
REQ-004 Derived constants: NW = RATE/IN_W words per block; BN_W = log2(IN_W/8).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
REQ-007 in  input  IN_W  message word; first byte is in[IN_W-1 -: 8].
REQ-008 in_ready  input  1  in is valid this cycle.
REQ-009 is_last  input  1  this word is the final, partial word of the message.
REQ-010 byte_num  input  BN_W  valid byte count of the final word, 0..IN_W/8-1; sampled only with is_last.
REQ-011 f_ack  input  1  one-cycle pulse from the permutation: the presented block has been taken.
REQ-012 buffer_full  output  1  high means the word is not accepted this cycle.
REQ-013 out  output  RATE  padded block; word 0 is at out[RATE-1 -: IN_W].
REQ-014 out_ready  output  1  out holds a complete block.
REQ-015 last_block  output  1  the presented block is the final block of the message; valid while out_ready=1.

Function
REQ-016 States: ACCEPT, FULL and DONE.
REQ-017 A word is accepted when in_ready=1, buffer_full=0 and the state is ACCEPT.
REQ-018 ACCEPT, non-last word: the word is stored in slot cnt (0..NW-1) and cnt increments.
- If the word lands in slot NW-1, the next state is FULL with last_block=0.
REQ-019 ACCEPT, is_last word: slot cnt receives the first byte_num bytes of in, then PAD_BYTE, then zero bytes.
- All remaining slots are zero.
- The block's final byte (out[7:0]) is ORed with 8'h80.
- If PAD_BYTE falls on out[7:0], that byte SHALL be PAD_BYTE|8'h80.
- Next state is FULL with last_block=1.
REQ-020 A message never needs an extra padding-only block.
- Because byte_num is at most IN_W/8-1, the padding always fits in the current block.
REQ-021 FULL: buffer_full=1, out_ready=1, and out is stable.
- On f_ack, the buffer clears to zero and cnt=0.
- Next state is ACCEPT if last_block=0, otherwise DONE.
REQ-022 DONE: buffer_full=1, out_ready=0, out is zero, and all inputs including f_ack are ignored until reset.
REQ-023 Latency: out_ready rises on the clock edge that accepts the completing word (one cycle).
- out_ready falls on the edge that samples f_ack.
REQ-024 A word presented in the same cycle as f_ack is not accepted (buffer_full=1).
- That word is accepted on a later cycle once buffer_full=0.
REQ-025 f_ack in ACCEPT is ignored.
REQ-026 is_last with byte_num=0 at cnt=0 yields a block of PAD_BYTE, zeros, then 8'h80 (empty-message padding).
REQ-027 buffer_full is registered.
- It rises in the same cycle as out_ready.
- It is never high in ACCEPT.

Reset
REQ-028 reset=1 at any clock edge, including mid-message and in FULL, SHALL force:
- state to ACCEPT and cnt to 0;
- out to all zeros;
- out_ready, buffer_full and last_block to 0.
REQ-029 Any input in a reset cycle is discarded.
- The first word accepted after reset is slot 0 of a new message.

Verification
REQ-030 Default parameters, one word is_last=1, byte_num=0 -> out_ready after 1 cycle, last_block=1, out = 8'h01, 70 zero bytes, 8'h80.
REQ-031 Default parameters, message "Hell","o, w","orld" then "!   " with byte_num=1, is_last=1 -> slot 3 = 32'h21010000, out[7:0]=8'h80, last_block=1.
REQ-032 Default parameters, 18 non-last words -> buffer_full=1 and last_block=0.
- A word with in_ready held high is not accepted.
- After f_ack the state returns to ACCEPT.
- The final word, given with is_last=1 and byte_num=3, produces block 2.
REQ-033 IN_W=64, RATE=1088, PAD_BYTE=8'h06: 16 words, then is_last with byte_num=7 in slot 16 -> out[7:0]=8'h86.
REQ-034 Reset asserted in FULL, then the same message driven again -> same out as a reset-free run.
- After the last f_ack, DONE holds out_ready=0 and buffer_full=1.
REQ-035 f_ack and in_ready both driven in FULL -> the word is accepted one cycle later into slot 0 and nothing is lost.
